// File: rtl/cp_insert.sv
// cp_insert: ping-pong buffered cyclic-prefix insertion for IFFT output symbols
module cp_insert #(
  parameter int N_FFT = 64,
  parameter int N_CP  = 16,
  parameter int DW    = 8
) (
  input  logic                               sys_clk,
  input  logic                               rst_n,
  input  logic [$clog2(N_FFT)-1:0]           din_index,
  input  logic signed [DW-1:0]               din_re,
  input  logic signed [DW-1:0]               din_im,
  input  logic                               din_vld,
  output logic signed [DW-1:0]               dout_re,
  output logic signed [DW-1:0]               dout_im,
  output logic                               dout_vld,
  output logic                               dout_cp,
  output logic                               dout_sym_start,
  output logic [$clog2(N_FFT+N_CP)-1:0]      dout_cnt,
  output logic                               ovf_flag
);
  localparam int AW = $clog2(N_FFT);
  localparam int CW = $clog2(N_FFT + N_CP);
  localparam logic [AW-1:0] LAST     = AW'(N_FFT - 1);
  localparam logic [AW-1:0] CP_START = AW'(N_FFT - N_CP);

  typedef enum logic [1:0] {IDLE, CP, BODY} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic                  rd_bank_q, rd_bank_d, wr_bank_q, wr_bank_d;
  logic                  drop_q, drop_d, ovf_q, ovf_d;
  logic [1:0]            full_q, full_d, full_avail, clr, set;
  logic                  sym0, cur_drop, wr_en;
  logic [2*DW-1:0]       mem [2][N_FFT];
  logic [2*DW-1:0]       rd_data;
  logic signed [DW-1:0]  re_q, re_d, im_q, im_d;
  logic                  vld_q, vld_d, cp_q, cp_d, ss_q, ss_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // A bank released this edge is already free for a symbol starting this edge
  always_comb begin
    full_avail = full_q & ~clr;
    sym0       = din_vld && din_index == '0;
    cur_drop   = sym0 ? full_avail[wr_bank_q] : drop_q;
    wr_en      = din_vld && !cur_drop;
    set        = (wr_en && din_index == LAST) ? 2'b01 << wr_bank_q : 2'b00;
    drop_d     = cur_drop;
    ovf_d      = ovf_q | (sym0 && full_avail[wr_bank_q]);
    wr_bank_d  = wr_bank_q ^ (|set);
    full_d     = full_avail | set;
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_bank_d = rd_bank_q;
    clr       = 2'b00;
    case (state_q)
      IDLE: begin
        rd_addr_d = CP_START;
        if (full_q[rd_bank_q]) state_d = CP;
      end
      CP: begin
        rd_addr_d = rd_addr_q + 1'b1;
        if (rd_addr_q == LAST) begin
          state_d   = BODY;
          rd_addr_d = '0;
        end
      end
      BODY: begin
        rd_addr_d = rd_addr_q + 1'b1;
        if (rd_addr_q == LAST) begin
          clr[rd_bank_q] = 1'b1;
          rd_bank_d      = ~rd_bank_q;
          state_d        = full_q[~rd_bank_q] ? CP : IDLE;
          rd_addr_d      = CP_START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_data = mem[rd_bank_q][rd_addr_q];
    vld_d   = state_q != IDLE;
    re_d    = vld_d ? rd_data[DW-1:0] : re_q;
    im_d    = vld_d ? rd_data[2*DW-1:DW] : im_q;
    cp_d    = state_q == CP;
    ss_d    = cp_d && rd_addr_q == CP_START;
    cnt_d   = cp_d ? CW'(rd_addr_q - CP_START) :
              state_q == BODY ? CW'(rd_addr_q) + CW'(N_CP) : '0;
  end

  always_ff @(posedge sys_clk)
    if (wr_en) mem[wr_bank_q][din_index] <= {din_im, din_re};

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      rd_bank_q <= 1'b0;
      wr_bank_q <= 1'b0;
      drop_q    <= 1'b0;
      ovf_q     <= 1'b0;
      full_q    <= 2'b00;
      re_q      <= '0;
      im_q      <= '0;
      vld_q     <= 1'b0;
      cp_q      <= 1'b0;
      ss_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_bank_q <= rd_bank_d;
      wr_bank_q <= wr_bank_d;
      drop_q    <= drop_d;
      ovf_q     <= ovf_d;
      full_q    <= full_d;
      re_q      <= re_d;
      im_q      <= im_d;
      vld_q     <= vld_d;
      cp_q      <= cp_d;
      ss_q      <= ss_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dout_re        = re_q;
  assign dout_im        = im_q;
  assign dout_vld       = vld_q;
  assign dout_cp        = cp_q;
  assign dout_sym_start = ss_q;
  assign dout_cnt       = cnt_q;
  assign ovf_flag       = ovf_q;
endmodule

// File: tb/tb_cp_insert.sv
// tb_cp_insert: table-driven symbol streams checked against a scoreboard of expected output samples
module tb_cp_insert;
  logic              sys_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [5:0]        din_index = '0;
  logic signed [7:0] din_re = '0, din_im = '0;
  logic              din_vld = 1'b0;
  logic signed [7:0] dout_re, dout_im;
  logic              dout_vld, dout_cp, dout_sym_start, ovf_flag;
  logic [6:0]        dout_cnt;

  typedef struct packed {
    logic [7:0] re;
    logic [7:0] im;
    logic       cp;
    logic       ss;
    logic [6:0] cnt;
  } smp_t;

  typedef struct {
    int nsym;
    int gap;
    int kind;
    bit hole;
    int keep;
    bit ovf;
    int runs;
  } vec_t;

  smp_t              exp_q[$];
  smp_t              obs[$];
  int                rd_ptr = 0, pass_cnt = 0, total_cnt = 0, vld_runs = 0;
  logic              prev_vld = 1'b0;
  logic signed [7:0] s_re[64], s_im[64];

  cp_insert dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .din_index(din_index), .din_re(din_re),
    .din_im(din_im), .din_vld(din_vld), .dout_re(dout_re), .dout_im(dout_im),
    .dout_vld(dout_vld), .dout_cp(dout_cp), .dout_sym_start(dout_sym_start),
    .dout_cnt(dout_cnt), .ovf_flag(ovf_flag)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (dout_vld) obs.push_back({dout_re, dout_im, dout_cp, dout_sym_start, dout_cnt});
    if (prev_vld && !dout_vld) vld_runs <= vld_runs + 1;
    prev_vld <= dout_vld;
  end

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic reset_dut();
    rst_n   = 1'b0;
    din_vld = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst dout_vld", dout_vld, 0);
    chk("rst dout_cp", dout_cp, 0);
    chk("rst dout_sym_start", dout_sym_start, 0);
    chk("rst dout_cnt", dout_cnt, 0);
    chk("rst dout_re", int'(dout_re), 0);
    chk("rst dout_im", int'(dout_im), 0);
    chk("rst ovf_flag", ovf_flag, 0);
    rst_n  = 1'b1;
    rd_ptr = obs.size();
    exp_q.delete();
  endtask

  task automatic send(input int kind, input bit hole, input int push_n, input int ovf0);
    smp_t e;
    int   a;
    for (int k = 0; k < 64; k++) begin
      s_re[k] = kind == 0 ? 8'(k) : kind == 1 ? (k[0] ? 8'sd127 : -8'sd128) : 8'($urandom);
      s_im[k] = kind == 0 ? 8'(-k) : kind == 1 ? (k[0] ? -8'sd128 : 8'sd127) : 8'($urandom);
    end
    for (int c = 0; c < push_n; c++) begin
      a     = c < 16 ? 48 + c : c - 16;
      e.re  = s_re[a];
      e.im  = s_im[a];
      e.cp  = c < 16;
      e.ss  = c == 0;
      e.cnt = 7'(c);
      exp_q.push_back(e);
    end
    for (int k = 0; k < 64; k++) begin
      if (hole && k == 32) begin
        @(negedge sys_clk);
        din_vld = 1'b0;
      end
      @(negedge sys_clk);
      if (ovf0 >= 0 && k == 1) chk("ovf_flag after index 0", ovf_flag, ovf0);
      din_vld   = 1'b1;
      din_index = 6'(k);
      din_re    = s_re[k];
      din_im    = s_im[k];
    end
  endtask

  task automatic drain(input string name);
    smp_t g, e;
    @(negedge sys_clk);
    din_vld = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (obs.size() - rd_ptr >= exp_q.size()) break;
      @(negedge sys_clk);
    end
    repeat (20) @(negedge sys_clk);
    while (rd_ptr < obs.size()) begin
      g = obs[rd_ptr];
      rd_ptr++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL %s extra sample: got cnt=%0d re=%0d, expected no output", name, g.cnt, $signed(g.re));
      end else begin
        e = exp_q.pop_front();
        if (g == e) pass_cnt++;
        else $display("FAIL %s sample: got re=%0d im=%0d cp=%0d ss=%0d cnt=%0d expected re=%0d im=%0d cp=%0d ss=%0d cnt=%0d",
                      name, $signed(g.re), $signed(g.im), g.cp, g.ss, g.cnt,
                      $signed(e.re), $signed(e.im), e.cp, e.ss, e.cnt);
      end
    end
    chk({name, " missing samples"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    vec_t vecs[6];
    int   runs0;
    bit   found;
    vecs[0] = '{1, 0, 0, 0, 1, 0, 1};
    vecs[1] = '{2, 16, 2, 0, 2, 0, 1};
    vecs[2] = '{1, 0, 1, 0, 1, 0, 1};
    vecs[3] = '{1, 0, 0, 1, 1, 0, 1};
    vecs[4] = '{3, 0, 2, 0, 2, 1, 1};
    vecs[5] = '{2, 30, 2, 1, 2, 0, 2};
    for (int i = 0; i < 6; i++) begin
      reset_dut();
      runs0 = vld_runs;
      for (int s = 0; s < vecs[i].nsym; s++) begin
        send(vecs[i].kind, vecs[i].hole, s < vecs[i].keep ? 80 : 0,
             (vecs[i].ovf && s == vecs[i].nsym - 1) ? 1 : 0);
        if (s < vecs[i].nsym - 1)
          repeat (vecs[i].gap) begin
            @(negedge sys_clk);
            din_vld = 1'b0;
          end
      end
      drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d ovf_flag", i), ovf_flag, int'(vecs[i].ovf));
      chk($sformatf("vec%0d output runs", i), vld_runs - runs0, vecs[i].runs);
    end

    reset_dut();
    send(0, 1'b0, 80, -1);
    @(negedge sys_clk);
    din_vld = 1'b0;
    chk("latency vld after T", dout_vld, 0);
    @(negedge sys_clk);
    chk("latency vld after T+1", dout_vld, 0);
    @(negedge sys_clk);
    chk("latency vld after T+2", dout_vld, 1);
    chk("latency first re", int'(dout_re), 48);
    chk("latency first sym_start", dout_sym_start, 1);
    drain("latency");

    reset_dut();
    send(2, 1'b0, 41, -1);
    @(negedge sys_clk);
    din_vld = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (dout_vld && dout_cnt == 7'd40) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid-output cnt 40 reached", int'(found), 1);
    rst_n = 1'b0;
    @(negedge sys_clk);
    chk("midrst dout_vld", dout_vld, 0);
    chk("midrst dout_cp", dout_cp, 0);
    chk("midrst dout_sym_start", dout_sym_start, 0);
    chk("midrst dout_cnt", dout_cnt, 0);
    chk("midrst dout_re", int'(dout_re), 0);
    chk("midrst dout_im", int'(dout_im), 0);
    rst_n = 1'b1;
    drain("midrst");
    send(0, 1'b0, 80, -1);
    drain("after midrst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
